// File: rtl/hall_sequence_generator_if.sv
// Control and sensor-side signals of the Hall sequence generator, grouped so that
// a controller (master) drives the run controls and observes the emulated sensor lines.
interface hall_sequence_generator_if #(
  parameter int PW = 16
);
  logic          EN;
  logic          DIR;
  logic [PW-1:0] PERIOD;
  logic [2:0]    H;
  logic          STEP;
  logic          REV;
  logic [7:0]    STEPS;

  modport master (output EN, DIR, PERIOD, input H, STEP, REV, STEPS);
  modport slave  (input EN, DIR, PERIOD, output H, STEP, REV, STEPS);
endinterface

// File: rtl/hall_sequence_generator.sv
// Emulates three-phase Hall sensor outputs: a prescaled timebase paces a step counter
// that walks a six-state Gray sequence forward or backward at a programmable rate.
module hall_sequence_generator #(
  parameter int PRESCALE = 50,
  parameter int PW       = 16
) (
  input logic                      CLK,
  input logic                      RST,
  hall_sequence_generator_if.slave bus
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PRESCALE_M1 = CW'(PRESCALE - 1);

  // The state encoding is the Hall code itself, so H comes straight off the flops.
  typedef enum logic [2:0] {
    S0 = 3'b001,
    S1 = 3'b011,
    S2 = 3'b010,
    S3 = 3'b110,
    S4 = 3'b100,
    S5 = 3'b101
  } hall_state_e;

  hall_state_e   state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic          dir_q, dir_d;
  logic          en_q, en_d;
  logic          step_q, step_d;
  logic          rev_q, rev_d;
  logic [7:0]    steps_q, steps_d;
  logic          tick;

  function automatic hall_state_e next_state(hall_state_e s, logic reverse);
    case (s)
      S0:      return reverse ? S5 : S1;
      S1:      return reverse ? S0 : S2;
      S2:      return reverse ? S1 : S3;
      S3:      return reverse ? S2 : S4;
      S4:      return reverse ? S3 : S5;
      S5:      return reverse ? S4 : S0;
      default: return S0;
    endcase
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    dir_d   = dir_q;
    en_d    = bus.EN;
    steps_d = steps_q;
    step_d  = 1'b0;
    rev_d   = 1'b0;
    tick    = 1'b0;

    if (!bus.EN) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (!en_q) begin
      // Enabling edge only captures the run settings; the timebase starts from zero.
      per_d   = bus.PERIOD;
      dir_d   = bus.DIR;
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      tick    = (presc_q == PRESCALE_M1);
      presc_d = tick ? '0 : presc_q + CW'(1);
      if (tick) begin
        if (per_q == '0) begin
          // Stopped: keep polling PERIOD once per tick until it becomes nonzero.
          per_d = bus.PERIOD;
          cnt_d = '0;
        end else if (cnt_q == per_q - PW'(1)) begin
          cnt_d   = '0;
          per_d   = bus.PERIOD;
          dir_d   = bus.DIR;
          state_d = next_state(state_q, dir_q);
          steps_d = steps_q + 8'd1;
          step_d  = 1'b1;
          rev_d   = (state_d == S0);
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S0;
      presc_q <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      step_q  <= 1'b0;
      rev_q   <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      steps_q <= steps_d;
    end
  end

  assign bus.H     = state_q;
  assign bus.STEP  = step_q;
  assign bus.REV   = rev_q;
  assign bus.STEPS = steps_q;

endmodule
